// File: rtl/if_fetch_unit.sv
// +-------------------------------------------------------------------------+
// | if_fetch_unit : PC owner, imem req/ready master, IF/ID slot with skid    |
// | Revision      : 1.0                                                      |
// +-------------------------------------------------------------------------+
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hFC00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_PCWrite,
  input  logic        c_redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instru,
  output logic [5:0]  ctr,
  output logic [5:0]  funcode,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_KILL  = 2'd2;

  logic [1:0]  state_q,   state_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] instru_q,  instru_d;
  logic [31:0] pc_out_q,  pc_out_d;
  logic        valid_q,   valid_d;
  logic [31:0] skid_q,    skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        accept;

  assign accept = c_PCWrite | ~valid_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instru_q  <= NOP_INSTR;
      pc_out_q  <= 32'h0;
      valid_q   <= 1'b0;
      skid_q    <= 32'h0;
      skid_pc_q <= 32'h0;
      pend_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instru_q  <= instru_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (c_redirect && !imem_ready)
          state_d = ST_KILL;
        else if (imem_ready && !c_redirect && !accept)
          state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (c_redirect || c_PCWrite)
          state_d = ST_FETCH;
      end
      ST_KILL: begin
        if (imem_ready)
          state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    pc_d      = pc_q;
    instru_d  = instru_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          if (c_redirect) begin
            pc_d     = redirect_pc;
            instru_d = NOP_INSTR;
            pc_out_d = 32'h0;
            valid_d  = 1'b0;
          end else if (accept) begin
            instru_d = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
          end else begin
            skid_d    = imem_rdata;
            skid_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
          end
        end else begin
          if (c_redirect) begin
            pend_pc_d = redirect_pc;
            instru_d  = NOP_INSTR;
            pc_out_d  = 32'h0;
            valid_d   = 1'b0;
          end else if (c_PCWrite) begin
            instru_d = NOP_INSTR;
            pc_out_d = 32'h0;
            valid_d  = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (c_redirect) begin
          pc_d     = redirect_pc;
          instru_d = NOP_INSTR;
          pc_out_d = 32'h0;
          valid_d  = 1'b0;
        end else if (c_PCWrite) begin
          instru_d = skid_q;
          pc_out_d = skid_pc_q;
          valid_d  = 1'b1;
        end
      end
      ST_KILL: begin
        instru_d = NOP_INSTR;
        pc_out_d = 32'h0;
        valid_d  = 1'b0;
        if (c_redirect)
          pend_pc_d = redirect_pc;
        // A redirect arriving with the discarded response takes precedence
        if (imem_ready)
          pc_d = c_redirect ? redirect_pc : pend_pc_q;
      end
      default: ;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req  = (state_q != ST_HOLD);
    imem_addr = pc_q;
    instru    = instru_q;
    ctr       = instru_q[31:26];
    funcode   = instru_q[5:0];
    pc_out    = pc_out_q;
    valid_out = valid_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns addr|0x20000000.
`default_nettype none

module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_PCWrite;
  logic        c_redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instru;
  logic [5:0]  ctr;
  logic [5:0]  funcode;
  logic [31:0] pc_out;
  logic        valid_out;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr | 32'h2000_0000;

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .c_PCWrite  (c_PCWrite),
    .c_redirect (c_redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instru     (instru),
    .ctr        (ctr),
    .funcode    (funcode),
    .pc_out     (pc_out),
    .valid_out  (valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".instru"}, instru, NOP);
    chk({tag, ".ctr"}, {26'd0, ctr}, 32'h3F);
    chk({tag, ".pc_out"}, pc_out, 32'h0);
    chk({tag, ".valid"}, {31'd0, valid_out}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; c_PCWrite = 1'b1; c_redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    step(); step();
    // Reset state
    chk_bubble("rst");
    chk("rst.funcode", {26'd0, funcode}, 32'h0);
    chk("rst.req", {31'd0, imem_req}, 32'h1);
    chk("rst.addr", imem_addr, 32'h0);

    // 1: streaming, one instruction per cycle
    rst = 1'b0;
    step();
    chk("s1.pc0", pc_out, 32'h0);
    chk("s1.instr0", instru, 32'h2000_0000);
    chk("s1.ctr", {26'd0, ctr}, 32'h08);
    chk("s1.valid", {31'd0, valid_out}, 32'h1);
    step();
    chk("s1.pc4", pc_out, 32'h4);
    chk("s1.instr4", instru, 32'h2000_0004);
    step();
    chk("s1.pc8", pc_out, 32'h8);
    chk("s1.funcode8", {26'd0, funcode}, 32'h08);

    // 2: stall with a response in flight -> skid capture and HOLD
    c_PCWrite = 1'b0;
    step();
    chk("s2.req_hold", {31'd0, imem_req}, 32'h0);
    chk("s2.pc_held", pc_out, 32'h8);
    chk("s2.addr", imem_addr, 32'h10);
    step();
    chk("s2.req_hold2", {31'd0, imem_req}, 32'h0);
    step();
    chk("s2.pc_held3", pc_out, 32'h8);
    chk("s2.instr_held3", instru, 32'h2000_0008);
    c_PCWrite = 1'b1;
    step();
    chk("s2.skid_pc", pc_out, 32'hC);
    chk("s2.skid_instr", instru, 32'h2000_000C);
    chk("s2.req_resume", {31'd0, imem_req}, 32'h1);
    chk("s2.addr_resume", imem_addr, 32'h10);
    step();
    chk("s2.next_pc", pc_out, 32'h10);

    // 3: redirect with an outstanding request -> KILL
    imem_ready = 1'b0; c_redirect = 1'b1; redirect_pc = 32'h100;
    step();
    chk_bubble("s3");
    chk("s3.addr_kill", imem_addr, 32'h14);
    chk("s3.req_kill", {31'd0, imem_req}, 32'h1);
    c_redirect = 1'b0;
    step();
    chk("s3.addr_kill2", imem_addr, 32'h14);
    imem_ready = 1'b1;
    step();
    chk("s3.discard", instru, NOP);
    chk("s3.addr_new", imem_addr, 32'h100);
    step();
    chk("s3.pc_new", pc_out, 32'h100);
    chk("s3.instr_new", instru, 32'h2000_0100);

    // 4: redirect during HOLD
    c_PCWrite = 1'b0;
    step();
    chk("s4.req_hold", {31'd0, imem_req}, 32'h0);
    c_redirect = 1'b1; redirect_pc = 32'h200;
    step();
    chk_bubble("s4");
    chk("s4.addr", imem_addr, 32'h200);
    chk("s4.req", {31'd0, imem_req}, 32'h1);
    c_redirect = 1'b0; c_PCWrite = 1'b1;
    step();
    chk("s4.pc_new", pc_out, 32'h200);
    chk("s4.instr_new", instru, 32'h2000_0200);

    // 5: redirect beats stall; second redirect while in KILL wins
    c_PCWrite = 1'b0; c_redirect = 1'b1; redirect_pc = 32'h300; imem_ready = 1'b0;
    step();
    chk("s5.valid", {31'd0, valid_out}, 32'h0);
    chk("s5.addr_kill", imem_addr, 32'h204);
    redirect_pc = 32'h400;
    step();
    chk("s5.addr_kill2", imem_addr, 32'h204);
    c_redirect = 1'b0; imem_ready = 1'b1; c_PCWrite = 1'b1;
    step();
    chk("s5.addr_second", imem_addr, 32'h400);
    chk("s5.valid2", {31'd0, valid_out}, 32'h0);
    step();
    chk("s5.pc_second", pc_out, 32'h400);

    // 5b: redirect coincident with the discarded response in KILL
    c_redirect = 1'b1; redirect_pc = 32'h700; imem_ready = 1'b0;
    step();
    redirect_pc = 32'h800; imem_ready = 1'b1;
    step();
    chk("s5b.addr", imem_addr, 32'h800);
    c_redirect = 1'b0;

    // 6: reset mid-KILL
    c_redirect = 1'b1; redirect_pc = 32'h500; imem_ready = 1'b0;
    step();
    chk("s6.addr_kill", imem_addr, 32'h800);
    c_redirect = 1'b0; rst = 1'b1;
    step();
    chk_bubble("s6");
    chk("s6.addr", imem_addr, 32'h0);
    chk("s6.req", {31'd0, imem_req}, 32'h1);
    rst = 1'b0; imem_ready = 1'b1;
    step();
    chk("s6.pc0", pc_out, 32'h0);
    chk("s6.valid", {31'd0, valid_out}, 32'h1);

    // PC wrap
    c_redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    c_redirect = 1'b0;
    step();
    chk("wrap.pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap.instr", instru, 32'hFFFF_FFFC);
    chk("wrap.next_addr", imem_addr, 32'h0);
    step();
    chk("wrap.pc0", pc_out, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and drives a req/ready instruction-memory interface. It presents a registered instruction slot (instruction, opcode/funct slices, PC) to IF/ID, and buffers one returned instruction in a skid register when the pipeline stalls. Branch/jump redirects flush the slot to the standard bubble and discard any in-flight memory response.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'hFC000000, bubble encoding (opcode 6'b111111, all other bits zero).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
c_PCWrite  in  1  1 = downstream (IF/ID) accepts the slot this cycle; 0 = stall.
c_redirect  in  1  1 = redirect fetch to redirect_pc and flush the slot.
redirect_pc  in  32  redirect target; word-aligned.
imem_req  out  1  memory request valid.
imem_addr  out  32  request address.
imem_ready  in  1  response valid this cycle; may be asserted in the same cycle as imem_req.
imem_rdata  in  32  instruction word; valid when imem_ready=1.
instru  out  32  slot instruction.
ctr  out  6  instru[31:26].
funcode  out  6  instru[5:0].
pc_out  out  32  address of the slot instruction.
valid_out  out  1  1 = slot holds a real instruction.

Behaviour:
- All outputs are registered. ctr and funcode always equal the slices of instru.
- Reset (rst=1 at a clock edge, overrides everything, including mid-operation in any state):
  - pc=RESET_PC; state=FETCH.
  - instru=NOP_INSTR, ctr=6'b111111, funcode=0, pc_out=0, valid_out=0.
  - Skid and pending-redirect registers are cleared.
- "Bubble" means: instru=NOP_INSTR, pc_out=0, valid_out=0.
- "accept" = c_PCWrite | ~valid_out.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; the skid register is full.
  - KILL: imem_req=1, imem_addr=pc (the address of the discarded request).
- Memory rule: once imem_req is high, imem_addr is held constant until imem_ready.
- FETCH with imem_ready=1:
  - c_redirect: data discarded; pc<=redirect_pc; slot<=bubble; stay in FETCH.
  - else if accept: slot<=imem_rdata, pc_out<=pc, valid_out<=1; pc<=pc+4.
  - else: skid<=imem_rdata, skid_pc<=pc; pc<=pc+4; go to HOLD.
- FETCH with imem_ready=0:
  - c_redirect: pend_pc<=redirect_pc; slot<=bubble; go to KILL.
  - else if c_PCWrite: slot<=bubble (consumer drained, nothing new).
  - else: slot held.
- HOLD:
  - c_redirect: skid dropped; pc<=redirect_pc; slot<=bubble; go to FETCH.
  - else if c_PCWrite: slot<=skid, pc_out<=skid_pc, valid_out<=1; go to FETCH.
  - else: stay in HOLD, everything held.
- KILL: slot remains bubble.
  - c_redirect: pend_pc<=redirect_pc (latest redirect wins).
  - imem_ready=1: data discarded; pc<=pend_pc, or redirect_pc if c_redirect is high in the same cycle; go to FETCH.
- Priority: rst > c_redirect > c_PCWrite.
- PC arithmetic: 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
- Throughput and latency:
  - Zero-wait memory gives one instruction per cycle.
  - Slot update is one cycle after imem_ready.
  - Redirect-to-first-request is the next cycle (FETCH/HOLD) or the cycle after the discarded response (KILL).

Test Plan:
1. Reset with imem_ready tied to 1 and rdata=addr|32'h20000000 -> pc_out 0,4,8,... on consecutive cycles, valid_out=1 from the first edge after reset, ctr=6'b001000.
2. Stall: hold c_PCWrite=0 for 3 cycles while the slot is valid and a response arrives -> one skid capture, state HOLD, imem_req=0. On release, the slot shows the skid instruction (pc_out = previous+4), then fetch resumes with no word lost or duplicated.
3. Redirect to 32'h00000100 while imem_ready=0 (outstanding) -> slot bubble (instru=32'hFC000000, ctr=6'b111111). The late response is discarded, and the next imem_addr is 32'h00000100.
4. Redirect during HOLD -> skid dropped, slot bubble, imem_addr=redirect_pc on the next cycle.
5. Redirect and stall together, plus a second redirect in KILL -> redirect wins over the stall; the final fetch goes to the second target.
6. rst asserted mid-KILL -> next cycle pc=RESET_PC, state FETCH, all outputs at reset values. PC wrap test: 32'hFFFFFFFC -> next fetch address 0.
